hba_arbiter_rr: RTL and testbench
=================================

Name: hba_arbiter_rr

Overview:
Parametrised HBA bus arbiter for up to NUM_MASTERS masters, successor to the single-mode fixed-size arbiter.
- Grants the shared HBA bus to one master at a time, in fixed-priority or round-robin mode.
- Bounds how long one master may hold the bus (burst limit).
- Completes hung transfers with a watchdog acknowledge and records a sticky error.
- Sits beside hba_or_masters/hba_or_slaves in each project top. hba_xferack_timeout is ORed into the slave xferack vector on a spare slot; that slot's dbus is tied to 0.

Parameters:
NUM_MASTERS, 4, number of master request/grant pairs (1..16).
ARB_MODE, 1, 0 = fixed priority (master 0 highest), 1 = round-robin.
TIMEOUT_CYCLES, 255, BUSY cycles before watchdog ack; 0 disables the watchdog.
MAX_BURST, 0, transfers per grant before forced re-arbitration when others wait; 0 = unlimited.
MIDX_WIDTH, $clog2(NUM_MASTERS) (min 1), master index width.

Ports:
hba_clk  input  1  bus clock.
hba_reset  input  1  synchronous, active-high reset.
hba_mrequest  input  NUM_MASTERS  per-master bus request.
hba_select  input  1  ORed transfer-in-progress.
hba_xferack  input  1  ORed slave acknowledge.
err_clr  input  1  clears the sticky timeout error.
hba_mgrant  output  NUM_MASTERS  one-hot grant, registered.
hba_xferack_timeout  output  1  one-cycle watchdog ack, registered.
hba_timeout_err  output  1  sticky timeout flag.
hba_timeout_master  output  MIDX_WIDTH  index of the master that timed out, last event.

Behaviour:
- Clock and reset: one clock, hba_clk. hba_reset is synchronous and active-high.
- Reset values:
  - state = IDLE; hba_mgrant = 0; hba_xferack_timeout = 0; hba_timeout_err = 0; hba_timeout_master = 0.
  - RR pointer last = NUM_MASTERS-1, so master 0 wins first.
  - Burst and timeout counters = 0.
  - Reset mid-transfer drops the grant immediately; no ack is generated.
- IDLE: hba_mgrant = 0. If any request is high, pick the winner and go to GRANT. hba_mgrant is one-hot the next cycle (request at n -> grant at n+1).
  - Fixed mode: winner is the lowest requesting index.
  - RR mode: search from last+1 modulo NUM_MASTERS; on grant, last <= winner.
- GRANT: grant held.
  - hba_select = 1: go to BUSY, timeout counter <= 0.
  - Else if the granted master's request = 0: go to IDLE, grant cleared next cycle. There is a mandatory one dead cycle before the next grant.
- BUSY: grant held; requests ignored.
  - hba_xferack = 1: go to DONE, burst counter +1.
  - Else if TIMEOUT_CYCLES != 0 and counter == TIMEOUT_CYCLES-1: go to DONE. Next cycle: hba_xferack_timeout = 1 for exactly one cycle, hba_timeout_err <= 1, hba_timeout_master <= granted index. The burst counter also increments.
  - Else: counter +1.
  - xferack and the timeout threshold in the same cycle: xferack wins, no timeout.
- DONE: waits for hba_select = 0. This prevents re-entering BUSY on the master's trailing select. Then:
  - Granted request = 0: go to IDLE.
  - MAX_BURST != 0, burst count >= MAX_BURST, and any other request high: go to IDLE, forced release. Burst counter <= 0.
  - Otherwise: go to GRANT.
- Burst counter clears on every IDLE entry.
- Grant changes only in IDLE. The grant is never removed while hba_select = 1.
- err_clr clears hba_timeout_err. If err_clr and a new timeout occur in the same cycle, set wins.
- Counter width: $clog2(TIMEOUT_CYCLES+1). Burst counter width: $clog2(MAX_BURST+1), min 1. Both saturate, never wrap.
- NUM_MASTERS = 1: the RR pointer is constant and both modes are identical.

Decomposition:
- Shared package hba_pkg: arbiter state enum (IDLE, GRANT, BUSY, DONE), ARB_FIXED/ARB_RR constants, HBA width defaults (DBUS_WIDTH 8, PERIPH_ADDR_WIDTH 4, REG_ADDR_WIDTH 8).
- One sub-module, hba_rr_pick: combinational masked priority picker. Inputs: request vector, start index, mode. Outputs: one-hot winner, index, valid.
- The FSM, counters and error logic stay in hba_arbiter_rr.

Test Plan:
- Single master: master 0 requests at cycle 10 -> mgrant = 4'b0001 at cycle 11; select high at 12, xferack at 14, select low at 15; request dropped at 16 -> mgrant = 0 at 17.
- RR fairness, ARB_MODE = 1: all four request continuously, each does one transfer and drops its request -> grant order 0,1,2,3,0; in fixed mode the same stimulus -> 0,0,0 while master 0 re-requests.
- Burst limit, MAX_BURST = 2: master 1 holds request with master 2 waiting -> after 2 acks master 1 is released, mgrant = 4'b0100 two cycles after select drops. With master 2 idle, master 1 keeps the grant indefinitely.
- Watchdog, TIMEOUT_CYCLES = 8: master 3 selects and no slave acks -> hba_xferack_timeout one-cycle pulse on the 9th cycle after BUSY entry; hba_timeout_err = 1; hba_timeout_master = 3; err_clr later -> err = 0.
- Boundary: xferack arrives exactly on BUSY cycle 8 with TIMEOUT_CYCLES = 8 -> no timeout pulse, no error; err_clr asserted the same cycle as a timeout -> err stays 1.
- Reset mid-BUSY: hba_reset at BUSY cycle 3 -> next cycle mgrant = 0, no timeout pulse, err = 0, and the next RR grant goes to master 0.

Source files
------------

// File: rtl/hba_pkg.sv
// Shared HBA definitions: bus width defaults, arbitration modes and arbiter FSM states.
package hba_pkg;

    localparam int DBUS_WIDTH        = 8;
    localparam int PERIPH_ADDR_WIDTH = 4;
    localparam int REG_ADDR_WIDTH    = 8;

    localparam int ARB_FIXED = 0;
    localparam int ARB_RR    = 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_BUSY  = 2'd2,
        ST_DONE  = 2'd3
    } arb_state_e;

endpackage

// File: rtl/hba_rr_pick.sv
// Combinational masked priority picker: first requester at or after i_start (RR) or from index 0 (fixed).
module hba_rr_pick #(
    parameter int NUM_MASTERS = 4,
    parameter int MIDX_WIDTH  = 2
) (
    input  logic [NUM_MASTERS-1:0] i_req,
    input  logic [MIDX_WIDTH-1:0]  i_start,
    input  logic                   i_rr,
    output logic [NUM_MASTERS-1:0] o_grant,
    output logic [MIDX_WIDTH-1:0]  o_idx,
    output logic                   o_valid
);

    always_comb begin
        int                    v_base;
        logic [MIDX_WIDTH-1:0] v_pos;
        o_grant = '0;
        o_idx   = '0;
        o_valid = 1'b0;
        v_base  = i_rr ? int'(i_start) : 0;
        v_pos   = '0;
        for (int k = 0; k < NUM_MASTERS; k++) begin
            v_pos = MIDX_WIDTH'((v_base + k) % NUM_MASTERS);
            if (!o_valid && i_req[v_pos]) begin
                o_valid        = 1'b1;
                o_grant[v_pos] = 1'b1;
                o_idx          = v_pos;
            end
        end
    end

endmodule

// File: rtl/hba_arbiter_rr.sv
// HBA bus arbiter: fixed-priority or round-robin grant, burst limit, and a watchdog
// that completes hung transfers with a one-cycle ack and a sticky error.
module hba_arbiter_rr
    import hba_pkg::*;
#(
    parameter int NUM_MASTERS    = 4,
    parameter int ARB_MODE       = 1,
    parameter int TIMEOUT_CYCLES = 255,
    parameter int MAX_BURST      = 0,
    parameter int MIDX_WIDTH     = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1
) (
    input  logic                   hba_clk,
    input  logic                   hba_reset,
    input  logic [NUM_MASTERS-1:0] hba_mrequest,
    input  logic                   hba_select,
    input  logic                   hba_xferack,
    input  logic                   err_clr,
    output logic [NUM_MASTERS-1:0] hba_mgrant,
    output logic                   hba_xferack_timeout,
    output logic                   hba_timeout_err,
    output logic [MIDX_WIDTH-1:0]  hba_timeout_master
);

    localparam int TO_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam int BU_W = (MAX_BURST > 0) ? $clog2(MAX_BURST + 1) : 1;
    localparam logic [TO_W-1:0]       TO_LAST  = (TIMEOUT_CYCLES > 0) ? TO_W'(TIMEOUT_CYCLES - 1) : '0;
    localparam logic [BU_W-1:0]       BU_MAX   = BU_W'(MAX_BURST);
    localparam logic [MIDX_WIDTH-1:0] LAST_IDX = MIDX_WIDTH'(NUM_MASTERS - 1);

    arb_state_e             r_state;
    logic [NUM_MASTERS-1:0] r_grant;
    logic [MIDX_WIDTH-1:0]  r_gidx;
    logic [MIDX_WIDTH-1:0]  r_last;
    logic [TO_W-1:0]        r_to_cnt;
    logic [BU_W-1:0]        r_burst;
    logic                   r_to_pulse;
    logic                   r_err;
    logic [MIDX_WIDTH-1:0]  r_to_master;

    logic [MIDX_WIDTH-1:0]  w_start;
    logic [NUM_MASTERS-1:0] w_oh;
    logic [MIDX_WIDTH-1:0]  w_idx;
    logic                   w_vld;
    logic                   w_rr;
    logic                   w_own_req;
    logic                   w_other_req;
    logic                   w_to_hit;
    logic                   w_burst_full;

    assign w_rr         = (ARB_MODE == ARB_RR);
    assign w_start      = (r_last == LAST_IDX) ? '0 : r_last + 1'b1;
    assign w_own_req    = |(hba_mrequest & r_grant);
    assign w_other_req  = |(hba_mrequest & ~r_grant);
    // xferack has priority over the watchdog when both land on the same BUSY cycle
    assign w_to_hit     = (TIMEOUT_CYCLES != 0) && (r_state == ST_BUSY) &&
                          !hba_xferack && (r_to_cnt == TO_LAST);
    assign w_burst_full = (MAX_BURST != 0) && (r_burst >= BU_MAX);

    hba_rr_pick #(
        .NUM_MASTERS (NUM_MASTERS),
        .MIDX_WIDTH  (MIDX_WIDTH)
    ) u_pick (
        .i_req   (hba_mrequest),
        .i_start (w_start),
        .i_rr    (w_rr),
        .o_grant (w_oh),
        .o_idx   (w_idx),
        .o_valid (w_vld)
    );

    always_ff @(posedge hba_clk) begin
        if (hba_reset) begin
            r_state     <= ST_IDLE;
            r_grant     <= '0;
            r_gidx      <= '0;
            r_last      <= LAST_IDX;
            r_to_cnt    <= '0;
            r_burst     <= '0;
            r_to_pulse  <= 1'b0;
            r_err       <= 1'b0;
            r_to_master <= '0;
        end else begin
            r_to_pulse <= 1'b0;
            // a timeout in flight (decision or pulse cycle) beats a concurrent clear
            if (w_to_hit || r_to_pulse) begin
                r_err <= 1'b1;
            end else if (err_clr) begin
                r_err <= 1'b0;
            end

            case (r_state)
                ST_IDLE: begin
                    r_burst <= '0;
                    if (w_vld) begin
                        r_state <= ST_GRANT;
                        r_grant <= w_oh;
                        r_gidx  <= w_idx;
                        r_last  <= w_idx;
                    end
                end
                ST_GRANT: begin
                    if (hba_select) begin
                        r_state  <= ST_BUSY;
                        r_to_cnt <= '0;
                    end else if (!w_own_req) begin
                        r_state <= ST_IDLE;
                        r_grant <= '0;
                        r_burst <= '0;
                    end
                end
                ST_BUSY: begin
                    if (hba_xferack || w_to_hit) begin
                        r_state <= ST_DONE;
                        if (r_burst != '1) begin
                            r_burst <= r_burst + 1'b1;
                        end
                        if (w_to_hit) begin
                            r_to_pulse  <= 1'b1;
                            r_to_master <= r_gidx;
                        end
                    end else if (r_to_cnt != '1) begin
                        r_to_cnt <= r_to_cnt + 1'b1;
                    end
                end
                ST_DONE: begin
                    // hold off until the master's trailing select is gone
                    if (!hba_select) begin
                        if (!w_own_req || (w_burst_full && w_other_req)) begin
                            r_state <= ST_IDLE;
                            r_grant <= '0;
                            r_burst <= '0;
                        end else begin
                            r_state <= ST_GRANT;
                        end
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_grant <= '0;
                end
            endcase
        end
    end

    assign hba_mgrant          = r_grant;
    assign hba_xferack_timeout = r_to_pulse;
    assign hba_timeout_err     = r_err;
    assign hba_timeout_master  = r_to_master;

endmodule

// File: tb/tb_hba_arbiter_rr.sv
// Directed bench: one round-robin arbiter (burst 2, watchdog 8) and one fixed-priority arbiter on shared stimulus.
module tb_hba_arbiter_rr;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] req;
    logic       sel;
    logic       ack;
    logic       clr;

    logic [3:0] gnt_r, gnt_f;
    logic       tp_r, tp_f;
    logic       err_r, err_f;
    logic [1:0] tm_r, tm_f;

    int n_tot = 0;
    int n_bad = 0;
    int ord[5] = '{0, 1, 2, 3, 0};

    always #5 clk = ~clk;

    hba_arbiter_rr #(
        .NUM_MASTERS    (4),
        .ARB_MODE       (1),
        .TIMEOUT_CYCLES (8),
        .MAX_BURST      (2)
    ) u_rr (
        .hba_clk             (clk),
        .hba_reset           (rst),
        .hba_mrequest        (req),
        .hba_select          (sel),
        .hba_xferack         (ack),
        .err_clr             (clr),
        .hba_mgrant          (gnt_r),
        .hba_xferack_timeout (tp_r),
        .hba_timeout_err     (err_r),
        .hba_timeout_master  (tm_r)
    );

    hba_arbiter_rr #(
        .NUM_MASTERS    (4),
        .ARB_MODE       (0),
        .TIMEOUT_CYCLES (8),
        .MAX_BURST      (0)
    ) u_fx (
        .hba_clk             (clk),
        .hba_reset           (rst),
        .hba_mrequest        (req),
        .hba_select          (sel),
        .hba_xferack         (ack),
        .err_clr             (clr),
        .hba_mgrant          (gnt_f),
        .hba_xferack_timeout (tp_f),
        .hba_timeout_err     (err_f),
        .hba_timeout_master  (tm_f)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tot++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step;
        @(negedge clk);
    endtask

    task automatic do_reset;
        rst = 1'b1;
        req = 4'b0000;
        sel = 1'b0;
        ack = 1'b0;
        clr = 1'b0;
        step;
        step;
        rst = 1'b0;
    endtask

    // Called in a GRANT cycle; returns in the cycle after DONE.
    task automatic xfer(input int m, input bit drop, input bit rereq);
        sel = 1'b1;
        step;
        ack = 1'b1;
        step;
        ack = 1'b0;
        sel = 1'b0;
        if (drop) req[m] = 1'b0;
        step;
        if (rereq) req[m] = 1'b1;
    endtask

    initial begin
        logic [3:0] e;

        do_reset;
        chk("rst_gnt_rr", gnt_r, 0);
        chk("rst_gnt_fx", gnt_f, 0);
        chk("rst_tp", tp_r, 0);
        chk("rst_err", err_r, 0);
        chk("rst_tm", tm_r, 0);
        chk("rst_fx_misc", {tp_f, err_f, tm_f}, 0);

        // single master
        req = 4'b0001;
        step;
        chk("sm_gnt", gnt_r, 4'b0001);
        step;
        chk("sm_hold", gnt_r, 4'b0001);
        xfer(0, 1'b0, 1'b0);
        chk("sm_regrant", gnt_r, 4'b0001);
        req = 4'b0000;
        step;
        chk("sm_release", gnt_r, 4'b0000);

        // fairness: every master requests, does one transfer, re-requests
        do_reset;
        req = 4'b1111;
        step;
        for (int i = 0; i < 5; i++) begin
            e = 4'b0001 << ord[i];
            chk("rr_order", gnt_r, e);
            chk("fx_order", gnt_f, 4'b0001);
            xfer(ord[i], 1'b1, 1'b1);
            chk("rr_dead", gnt_r, 0);
            step;
        end

        // burst limit with master 2 waiting
        do_reset;
        req = 4'b0010;
        step;
        chk("bl_gnt", gnt_r, 4'b0010);
        req = 4'b0110;
        xfer(1, 1'b0, 1'b0);
        chk("bl_keep", gnt_r, 4'b0010);
        xfer(1, 1'b0, 1'b0);
        chk("bl_release", gnt_r, 4'b0000);
        step;
        chk("bl_next", gnt_r, 4'b0100);

        // burst limit without contention
        do_reset;
        req = 4'b0010;
        step;
        for (int i = 0; i < 4; i++) begin
            chk("bl_solo", gnt_r, 4'b0010);
            xfer(1, 1'b0, 1'b0);
        end
        chk("bl_solo_end", gnt_r, 4'b0010);

        // watchdog
        do_reset;
        req = 4'b1000;
        step;
        chk("wd_gnt", gnt_r, 4'b1000);
        sel = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step;
            chk("wd_quiet", tp_r, 0);
        end
        step;
        chk("wd_pulse", tp_r, 1);
        chk("wd_err", err_r, 1);
        chk("wd_master", tm_r, 3);
        chk("wd_hold", gnt_r, 4'b1000);
        step;
        chk("wd_pulse_end", tp_r, 0);
        sel = 1'b0;
        req = 4'b0000;
        step;
        step;
        chk("wd_sticky", err_r, 1);
        clr = 1'b1;
        step;
        clr = 1'b0;
        chk("wd_clr", err_r, 0);

        // xferack on the threshold cycle
        do_reset;
        req = 4'b1000;
        step;
        sel = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step;
            chk("bd_quiet", tp_r, 0);
            if (i == 7) ack = 1'b1;
        end
        step;
        ack = 1'b0;
        chk("bd_nopulse", tp_r, 0);
        chk("bd_noerr", err_r, 0);
        chk("bd_gnt", gnt_r, 4'b1000);
        step;
        chk("bd_nopulse2", tp_r, 0);
        sel = 1'b0;
        req = 4'b0000;
        step;

        // err_clr colliding with a timeout
        do_reset;
        req = 4'b1000;
        step;
        sel = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step;
            if (i == 7) clr = 1'b1;
        end
        step;
        chk("cc_pulse", tp_r, 1);
        step;
        clr = 1'b0;
        chk("cc_err", err_r, 1);
        step;
        chk("cc_err_hold", err_r, 1);
        sel = 1'b0;
        req = 4'b0000;
        step;

        // reset in the middle of BUSY
        do_reset;
        req = 4'b0100;
        step;
        chk("rb_gnt", gnt_r, 4'b0100);
        sel = 1'b1;
        step;
        step;
        step;
        rst = 1'b1;
        step;
        chk("rb_drop", gnt_r, 0);
        chk("rb_tp", tp_r, 0);
        chk("rb_err", err_r, 0);
        rst = 1'b0;
        sel = 1'b0;
        req = 4'b1111;
        step;
        chk("rb_first", gnt_r, 4'b0001);
        chk("rb_tp2", tp_r, 0);

        $display("test done: total=%0d bad=%0d", n_tot, n_bad);
        $finish;
    end

endmodule
